adc_capture_reader: RTL

// Read-side counterpart of the ADC capture path. After a capture has filled the three 32-bit sample RAM banks,

---
 rtl/adc_capture_reader_if.sv | 31 +++
 rtl/adc_capture_reader.sv | 139 +++++++++++++
 2 files changed

// File: rtl/adc_capture_reader_if.sv
// Bundle between the capture reader, the sample RAM banks and the HPS/ARM bridge.
// The master side is the reader itself; the slave side is RAM plus consumer.
interface adc_capture_reader_if #(
  parameter int unsigned ADDR_W = 13
);
  logic              iStart;
  logic [ADDR_W-1:0] iRecLength;
  logic              oRDEN;
  logic [ADDR_W-1:0] oRAddr;
  logic [31:0]       iRData0;
  logic [31:0]       iRData1;
  logic [31:0]       iRData2;
  logic [95:0]       oSample;
  logic [ADDR_W-1:0] oSampleIdx;
  logic              oValid;
  logic              iReady;
  logic              oLast;
  logic              oBusy;
  logic              oDone;
  logic              oStartIgnored;

  modport master (
    input  iStart, iRecLength, iRData0, iRData1, iRData2, iReady,
    output oRDEN, oRAddr, oSample, oSampleIdx, oValid, oLast, oBusy, oDone, oStartIgnored
  );

  modport slave (
    output iStart, iRecLength, iRData0, iRData1, iRData2, iReady,
    input  oRDEN, oRAddr, oSample, oSampleIdx, oValid, oLast, oBusy, oDone, oStartIgnored
  );
endinterface

// File: rtl/adc_capture_reader.sv
// Reads the three sample RAM banks in address order, unpacks each 96-bit word into eight
// 12-bit channels and streams them out through a small FIFO with valid/ready flow control.
module adc_capture_reader #(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned RAM_LAT = 2,
  parameter int unsigned FIFO_D  = 4
) (
  input logic                  ref_frame_clk,
  input logic                  iStateReset,
  adc_capture_reader_if.master bus
);

  localparam int unsigned CW = $clog2(FIFO_D + 1);
  localparam int unsigned PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int unsigned EW = 97 + ADDR_W;
  localparam logic [CW:0]   OccMax = (CW + 1)'(FIFO_D);
  localparam logic [PW-1:0] PtrMax = PW'(FIFO_D - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] len_q, rd_addr_q;
  logic              busy_q, done_q, ignored_q;
  logic [RAM_LAT-1:0] pipe_vld_q, pipe_last_q;
  logic [ADDR_W-1:0] pipe_idx_q [RAM_LAT];
  logic [EW-1:0]     fifo_mem_q [FIFO_D];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;

  logic [CW:0]       inflight, occupancy;
  logic              issue, push, pop, valid;
  logic [ADDR_W-1:0] last_addr;
  logic [95:0]       unpacked;
  logic [EW-1:0]     head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RAM_LAT; i++) inflight = inflight + (CW + 1)'(pipe_vld_q[i]);
  end

  // Reads in flight reserve FIFO space, so a returning word always has a slot.
  assign occupancy = {1'b0, count_q} + inflight;
  assign last_addr = len_q - ADDR_W'(1);
  assign issue = (state_q == StRead) && (rd_addr_q < len_q) && (occupancy < OccMax) &&
                 !iStateReset;
  assign push  = pipe_vld_q[RAM_LAT-1];
  assign head  = fifo_mem_q[rd_ptr_q];
  assign valid = (count_q != '0) && !iStateReset;
  assign pop   = valid && bus.iReady;

  assign unpacked = {bus.iRData1[27:24], bus.iRData2[31:24],
                     bus.iRData0[31:24], bus.iRData1[31:28],
                     bus.iRData2[23:12], bus.iRData2[11:0],
                     bus.iRData1[23:12], bus.iRData1[11:0],
                     bus.iRData0[23:12], bus.iRData0[11:0]};

  assign bus.oRDEN         = issue;
  assign bus.oRAddr        = issue ? rd_addr_q : '0;
  assign bus.oValid        = valid;
  assign bus.oSample       = valid ? head[95:0] : '0;
  assign bus.oSampleIdx    = valid ? head[95+ADDR_W:96] : '0;
  assign bus.oLast         = valid & head[EW-1];
  assign bus.oBusy         = busy_q & ~iStateReset;
  assign bus.oDone         = done_q & ~iStateReset;
  assign bus.oStartIgnored = ignored_q & ~iStateReset;

  // Data-path storage; qualified by pipe_vld_q / count_q so it needs no reset.
  always_ff @(posedge ref_frame_clk) begin
    pipe_idx_q[0]  <= rd_addr_q;
    pipe_last_q[0] <= (rd_addr_q == last_addr);
    for (int i = RAM_LAT - 1; i > 0; i--) begin
      pipe_idx_q[i]  <= pipe_idx_q[i-1];
      pipe_last_q[i] <= pipe_last_q[i-1];
    end
    if (push && !iStateReset) begin
      fifo_mem_q[wr_ptr_q] <= {pipe_last_q[RAM_LAT-1], pipe_idx_q[RAM_LAT-1], unpacked};
    end
  end

  always_ff @(posedge ref_frame_clk) begin
    if (iStateReset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ignored_q  <= 1'b0;
      pipe_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      done_q    <= 1'b0;
      ignored_q <= 1'b0;

      pipe_vld_q[0] <= issue;
      for (int i = RAM_LAT - 1; i > 0; i--) pipe_vld_q[i] <= pipe_vld_q[i-1];
      if (issue) rd_addr_q <= rd_addr_q + ADDR_W'(1);

      if (push) wr_ptr_q <= (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      unique case (state_q)
        StIdle: begin
          if (bus.iStart) begin
            len_q     <= bus.iRecLength;
            rd_addr_q <= '0;
            if (bus.iRecLength == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRead;
              busy_q  <= 1'b1;
            end
          end
        end
        StRead: begin
          ignored_q <= bus.iStart;
          if (pop && head[EW-1]) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          ignored_q <= bus.iStart;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
